// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock and EX forwarding scheduler for the 5-stage LA32 core.
// Tracks EX/MEM destinations and drives per-stage enables, flushes and fwd selects.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 3,
    parameter int REG_LOG    = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [3*REG_LOG-1:0] id_rs,
    input  logic [1:0]           id_reg_wb,
    input  logic [1:0]           id_mem,
    input  logic [3:0]           id_ex,
    input  logic                 ex_branch_taken,
    input  logic                 mem_ready,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic [1:0]           ex_fwd_j,
    output logic [1:0]           ex_fwd_k,
    output logic [1:0]           ex_fwd_d
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef logic [REG_LOG-1:0] reg_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;

    // ID decode
    reg_t src_j;
    reg_t src_k;
    reg_t src_d;
    reg_t id_dst;
    logic use_d;
    logic id_load;
    logic id_memop;
    logic id_mul;
    logic unused_dec;

    assign src_d    = id_rs[REG_LOG-1:0];
    assign src_j    = id_rs[2*REG_LOG-1:REG_LOG];
    assign src_k    = id_rs[3*REG_LOG-1:2*REG_LOG];
    assign use_d    = !id_reg_wb[1] && (id_mem[0] || id_ex[3]);
    assign id_dst   = id_reg_wb[1] ? src_d : '0;
    assign id_load  = id_mem[1];
    assign id_memop = id_mem[1] | id_mem[0];
    assign id_mul   = id_ex[2];
    assign unused_dec = ^{id_reg_wb[0], id_ex[1:0]};

    // Tracked slots
    logic          ex_v;
    reg_t          ex_dst;
    logic          ex_load;
    logic          ex_memop;
    logic          ex_mul;
    logic          mem_v;
    reg_t          mem_dst;
    logic          mem_memop;
    logic [CW-1:0] mul_cnt;
    logic          unused_slot;

    assign unused_slot = ex_mul;

    // Register 0 is hardwired, so it never names a real producer.
    function automatic logic hit(input reg_t dst, input reg_t src);
        return (dst != '0) && (dst == src);
    endfunction

    function automatic logic [1:0] pick(input logic ex_h, input logic mem_h,
                                        input logic ex_ld);
        if (ex_h && !ex_ld)
            return FWD_EXM;
        else if (mem_h)
            return FWD_MWB;
        else
            return FWD_RF;
    endfunction

    logic ex_hit_j;
    logic ex_hit_k;
    logic ex_hit_d;
    logic mem_hit_j;
    logic mem_hit_k;
    logic mem_hit_d;

    assign ex_hit_j  = ex_v && hit(ex_dst, src_j);
    assign ex_hit_k  = ex_v && hit(ex_dst, src_k);
    assign ex_hit_d  = ex_v && use_d && hit(ex_dst, src_d);
    assign mem_hit_j = mem_v && hit(mem_dst, src_j);
    assign mem_hit_k = mem_v && hit(mem_dst, src_k);
    assign mem_hit_d = mem_v && use_d && hit(mem_dst, src_d);

    logic [1:0] nxt_fwd_j;
    logic [1:0] nxt_fwd_k;
    logic [1:0] nxt_fwd_d;

    assign nxt_fwd_j = pick(ex_hit_j, mem_hit_j, ex_load);
    assign nxt_fwd_k = pick(ex_hit_k, mem_hit_k, ex_load);
    assign nxt_fwd_d = pick(ex_hit_d, mem_hit_d, ex_load);

    // Hazard conditions
    logic mem_wait;
    logic mul_busy;
    logic load_use;

    assign mem_wait = mem_v && mem_memop && !mem_ready;
    assign mul_busy = (mul_cnt != '0);
    assign load_use = id_valid && ex_load &&
                      (ex_hit_j || ex_hit_k || ex_hit_d);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mul_busy) begin
            // MUL holds EX; a bubble drains into MEM behind it.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    logic ex_bubble;
    logic mul_start;

    assign ex_bubble = idex_flush || !id_valid;
    assign mul_start = idex_en && !idex_flush && id_valid && id_mul;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_v     <= 1'b0;
            ex_dst   <= '0;
            ex_load  <= 1'b0;
            ex_memop <= 1'b0;
            ex_mul   <= 1'b0;
            ex_fwd_j <= FWD_RF;
            ex_fwd_k <= FWD_RF;
            ex_fwd_d <= FWD_RF;
        end else if (idex_en) begin
            if (ex_bubble) begin
                ex_v     <= 1'b0;
                ex_dst   <= '0;
                ex_load  <= 1'b0;
                ex_memop <= 1'b0;
                ex_mul   <= 1'b0;
                ex_fwd_j <= FWD_RF;
                ex_fwd_k <= FWD_RF;
                ex_fwd_d <= FWD_RF;
            end else begin
                ex_v     <= 1'b1;
                ex_dst   <= id_dst;
                ex_load  <= id_load;
                ex_memop <= id_memop;
                ex_mul   <= id_mul;
                ex_fwd_j <= nxt_fwd_j;
                ex_fwd_k <= nxt_fwd_k;
                ex_fwd_d <= nxt_fwd_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_v     <= 1'b0;
            mem_dst   <= '0;
            mem_memop <= 1'b0;
        end else if (exmem_en) begin
            if (exmem_flush) begin
                mem_v     <= 1'b0;
                mem_dst   <= '0;
                mem_memop <= 1'b0;
            end else begin
                mem_v     <= ex_v;
                mem_dst   <= ex_dst;
                mem_memop <= ex_memop;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mul_cnt <= '0;
        else if (mul_start)
            mul_cnt <= CW'(MUL_CYCLES - 1);
        else if (mul_busy && !mem_wait)
            mul_cnt <= mul_cnt - CW'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl: one row per cycle,
// plus a hand sequence for reset in the middle of a MUL stall.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [14:0] id_rs;
    logic [1:0]  id_reg_wb;
    logic [1:0]  id_mem;
    logic [3:0]  id_ex;
    logic        ex_branch_taken;
    logic        mem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  ex_fwd_j, ex_fwd_k, ex_fwd_d;

    pipe_hazard_ctrl #(.MUL_CYCLES(3), .REG_LOG(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .id_reg_wb(id_reg_wb), .id_mem(id_mem), .id_ex(id_ex),
        .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush),
        .ex_fwd_j(ex_fwd_j), .ex_fwd_k(ex_fwd_k), .ex_fwd_d(ex_fwd_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [14:0] rs;
        logic [1:0]  wb;
        logic [1:0]  mem;
        logic [3:0]  ex;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       br;
        logic       rdy;
        logic [4:0] en;
        logic [2:0] fl;
        logic [5:0] fwd;
    } vec_t;

    // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem}
    localparam logic [4:0] EN_ALL = 5'b11111;
    localparam logic [4:0] EN_LU  = 5'b00111;
    localparam logic [4:0] EN_MB  = 5'b00011;
    localparam logic [4:0] EN_FRZ = 5'b00000;
    localparam logic [2:0] FL_NO  = 3'b000;
    localparam logic [2:0] FL_LU  = 3'b010;
    localparam logic [2:0] FL_MB  = 3'b001;
    localparam logic [2:0] FL_BR  = 3'b110;

    vec_t vecs [64];
    int   nvec = 0;
    int   passed = 0;
    int   total = 0;

    function automatic instr_t mk(input logic [4:0] rd, input logic [4:0] rj,
                                  input logic [4:0] rk, input logic [1:0] wb,
                                  input logic [1:0] mem, input logic [3:0] ex);
        instr_t i;
        i.v   = 1'b1;
        i.rs  = {rk, rj, rd};
        i.wb  = wb;
        i.mem = mem;
        i.ex  = ex;
        return i;
    endfunction

    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rj,
                                   input logic [4:0] rk);
        return mk(rd, rj, rk, 2'b10, 2'b00, 4'b0000);
    endfunction

    function automatic instr_t mul(input logic [4:0] rd, input logic [4:0] rj,
                                   input logic [4:0] rk);
        return mk(rd, rj, rk, 2'b10, 2'b00, 4'b0100);
    endfunction

    function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] rj);
        return mk(rd, rj, 5'd0, 2'b11, 2'b10, 4'b0000);
    endfunction

    function automatic instr_t st(input logic [4:0] rd, input logic [4:0] rj);
        return mk(rd, rj, 5'd0, 2'b00, 2'b01, 4'b0000);
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = mk(5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 4'b0000);
        i.v = 1'b0;
        return i;
    endfunction

    task automatic add(input instr_t ins, input logic br, input logic rdy,
                       input logic [4:0] en, input logic [2:0] fl,
                       input logic [5:0] fwd);
        vecs[nvec].ins = ins;
        vecs[nvec].br  = br;
        vecs[nvec].rdy = rdy;
        vecs[nvec].en  = en;
        vecs[nvec].fl  = fl;
        vecs[nvec].fwd = fwd;
        nvec++;
    endtask

    task automatic drive(input instr_t ins, input logic br, input logic rdy);
        id_valid        = ins.v;
        id_rs           = ins.rs;
        id_reg_wb       = ins.wb;
        id_mem          = ins.mem;
        id_ex           = ins.ex;
        ex_branch_taken = br;
        mem_ready       = rdy;
    endtask

    task automatic chk(input string name, input int row,
                       input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %b want %b", name, row, act, exp);
        else
            passed++;
    endtask

    task automatic chk_all(input string tag, input int row,
                           input logic [4:0] en, input logic [2:0] fl,
                           input logic [5:0] fwd);
        chk({tag, " en"}, row,
            {3'b0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {3'b0, en});
        chk({tag, " flush"}, row,
            {5'b0, ifid_flush, idex_flush, exmem_flush}, {5'b0, fl});
        chk({tag, " fwd"}, row,
            {2'b0, ex_fwd_j, ex_fwd_k, ex_fwd_d}, {2'b0, fwd});
    endtask

    initial begin
        // back-to-back ALU dependency, then one-apart dependency
        add(alu(4, 1, 2), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(alu(5, 4, 3), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(alu(6, 1, 2), 0, 1, EN_ALL, FL_NO, 6'b01_00_00);
        add(alu(7, 5, 3), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b10_00_00);
        // load-use: one stall, consumer then takes MEM/WB
        add(ld(4, 1),     0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(alu(5, 4, 4), 0, 1, EN_LU,  FL_LU, 6'b00_00_00);
        add(alu(5, 4, 4), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b10_10_00);
        // MUL occupancy, dependent forwards from EX/MEM
        add(mul(8, 1, 2), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(alu(9, 8, 1), 0, 1, EN_MB,  FL_MB, 6'b00_00_00);
        add(alu(9, 8, 1), 0, 1, EN_MB,  FL_MB, 6'b00_00_00);
        add(alu(9, 8, 1), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b01_00_00);
        // taken branch beats load-use
        add(ld(4, 1),     0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(alu(5, 4, 4), 1, 1, EN_ALL, FL_BR, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        // store waits in MEM; branch held off until ready
        add(st(3, 1),     0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(alu(9, 1, 2), 0, 0, EN_FRZ, FL_NO, 6'b00_00_00);
        add(alu(9, 1, 2), 1, 0, EN_FRZ, FL_NO, 6'b00_00_00);
        add(alu(9, 1, 2), 0, 0, EN_FRZ, FL_NO, 6'b00_00_00);
        add(alu(9, 1, 2), 1, 1, EN_ALL, FL_BR, 6'b00_00_00);
        // store data operand forwarding
        add(alu(6, 1, 2), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(st(6, 1),     0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b00_00_01);
        // register 0 never creates a hazard
        add(ld(0, 1),     0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(alu(5, 0, 0), 0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        // mem wait during MUL busy freezes the count
        add(ld(10, 1),    0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(mul(11, 2, 3),0, 1, EN_ALL, FL_NO, 6'b00_00_00);
        add(nop(),        0, 0, EN_FRZ, FL_NO, 6'b00_00_00);
        add(nop(),        0, 1, EN_MB,  FL_MB, 6'b00_00_00);
        add(nop(),        0, 1, EN_MB,  FL_MB, 6'b00_00_00);
        add(nop(),        0, 1, EN_ALL, FL_NO, 6'b00_00_00);

        rst = 1'b1;
        drive(nop(), 1'b0, 1'b1);
        #2;
        chk_all("in_reset", 0, EN_ALL, FL_NO, 6'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("after_reset", 0, EN_ALL, FL_NO, 6'b0);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            drive(vecs[i].ins, vecs[i].br, vecs[i].rdy);
            #1;
            chk_all("vec", i, vecs[i].en, vecs[i].fl, vecs[i].fwd);
        end

        // reset asserted while a MUL is occupying EX
        @(negedge clk);
        drive(mul(12, 1, 2), 1'b0, 1'b1);
        #1;
        chk_all("rst_mul_issue", 0, EN_ALL, FL_NO, 6'b0);
        @(negedge clk);
        drive(nop(), 1'b0, 1'b1);
        #1;
        chk_all("rst_mul_busy", 0, EN_MB, FL_MB, 6'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_all("rst_mid_stall", 0, EN_ALL, FL_NO, 6'b0);
        chk("rst_mul_cnt", 0, 8'(dut.mul_cnt), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all("rst_released", 0, EN_ALL, FL_NO, 6'b0);
        @(negedge clk);
        #1;
        chk_all("rst_no_resume", 0, EN_ALL, FL_NO, 6'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
